fib_table_gen: RTL and testbench

Parametrised Fibonacci table for the Fibonacci binary-system datapath. After reset it computes F(0)..F(DEPTH-1) itself with one adder, then serves two independent indexed read channels with a registered request/valid handshake, an out-of-range error flag and a sticky overflow flag. It replaces fixed hand-written constant tables wherever encoder/obfuscation stages need Fibonacci weights of arbitrary width and depth.

---
 rtl/fib_table_gen.sv | 200 ++++++++++++++++++++
 tb/tb_fib_table_gen.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_table_gen.sv
// -----------------------------------------------------------------------------
// fib_table_gen
//
// Self-filling Fibonacci weight table. After reset (or a restart pulse) a small
// fill FSM writes F(0)..F(DEPTH-1) into a register array, one entry per cycle,
// using a single WIDTH+1 bit adder. Once the table is filled, two independent
// read channels return mem[idx] one cycle after each request, or data=0 with
// err=1 when idx >= DEPTH.
//
// Optional feature macro: FIB_SAT_EN
//   defined   : an overflowing entry and every later entry store all-ones
//   undefined : entries wrap modulo 2^WIDTH (wrapped recurrence continues)
//   ovf is set the same way in both builds.
//
// Parameters
//   WIDTH  bit width of each stored value
//   DEPTH  number of entries, F(0)..F(DEPTH-1), DEPTH >= 2
//   IDX_W  index width, 2^IDX_W >= DEPTH
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   restart    synchronous request to recompute the table
//   init_busy  high while the table is being filled
//   ovf        sticky: some F(i) did not fit in WIDTH bits
//   req_a/b    read request, channel A/B
//   cnt_a/b    read index, channel A/B
//   vld_a/b    one-cycle result valid, channel A/B
//   err_a/b    index was out of range (qualified by vld)
//   mema/memb  read data, held until the next vld on that channel
// -----------------------------------------------------------------------------
module fib_table_gen #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 48,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  output logic             init_busy,
  output logic             ovf,
  input  logic             req_a,
  input  logic [IDX_W-1:0] cnt_a,
  output logic             vld_a,
  output logic             err_a,
  output logic [WIDTH-1:0] mema,
  input  logic             req_b,
  input  logic [IDX_W-1:0] cnt_b,
  output logic             vld_b,
  output logic             err_b,
  output logic [WIDTH-1:0] memb
);

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_W  = (IDX_W + 1)'(DEPTH);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   f_prev_q, f_cur_q;
  logic               ovf_q;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  logic [WIDTH:0]     sum;
  logic               wr_en;
  logic [WIDTH-1:0]   wr_data;
  logic               carry;
  logic               accept;

  // ---------------------------------------------------------------------------
  // Fill FSM: next state, write strobe and write value.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_data = '0;
    carry   = 1'b0;
    sum     = {1'b0, f_prev_q} + {1'b0, f_cur_q};

    unique case (state_q)
      FILL: begin
        wr_en = 1'b1;
        if (idx_q == '0) begin
          wr_data = '0;
        end else if (idx_q == IDX_W'(1)) begin
          wr_data = WIDTH'(1);
        end else begin
          carry = sum[WIDTH];
`ifdef FIB_SAT_EN
          // Once saturated, stay saturated for the rest of the table.
          wr_data = (ovf_q || sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
`else
          wr_data = sum[WIDTH-1:0];
`endif
        end
        if (idx_q == LAST_IDX) begin
          state_d = READY;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
      end
    endcase

    // Restart wins over everything: abandon the current fill or ready state.
    if (restart) begin
      state_d = FILL;
      idx_d   = '0;
      wr_en   = 1'b0;
      carry   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FILL;
      idx_q    <= '0;
      f_prev_q <= '0;
      f_cur_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (wr_en) begin
        // The running pair shifts with each write, so the array itself is
        // never read back during the fill.
        f_prev_q <= f_cur_q;
        f_cur_q  <= wr_data;
      end
      if (restart) begin
        ovf_q <= 1'b0;
      end else if (carry) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // NOTE: the table array has no reset; every entry is rewritten by the fill
  // before any read is accepted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[idx_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read channels. Requests are dropped during fill and in a restart cycle.
  // ---------------------------------------------------------------------------
  assign accept = (state_q == READY) && !restart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a <= 1'b0;
      err_a <= 1'b0;
      mema  <= '0;
      vld_b <= 1'b0;
      err_b <= 1'b0;
      memb  <= '0;
    end else begin
      vld_a <= accept && req_a;
      if (accept && req_a) begin
        if ({1'b0, cnt_a} < DEPTH_W) begin
          mema  <= mem_q[cnt_a];
          err_a <= 1'b0;
        end else begin
          mema  <= '0;
          err_a <= 1'b1;
        end
      end

      vld_b <= accept && req_b;
      if (accept && req_b) begin
        if ({1'b0, cnt_b} < DEPTH_W) begin
          memb  <= mem_q[cnt_b];
          err_b <= 1'b0;
        end else begin
          memb  <= '0;
          err_b <= 1'b1;
        end
      end
    end
  end

  assign init_busy = (state_q == FILL);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fib_table_gen.sv
// -----------------------------------------------------------------------------
// tb_fib_table_gen
//
// Scoreboard bench for fib_table_gen. Stimulus pushes the expected response of
// every request it expects to be accepted; negedge monitors pop and compare
// whenever a DUT presents vld. A second instance (WIDTH=16, DEPTH=32) covers
// overflow; its expected values follow FIB_SAT_EN.
// -----------------------------------------------------------------------------
module tb_fib_table_gen;

  localparam int DEPTH = 48;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Default instance
  logic        restart = 1'b0;
  logic        init_busy, ovf;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [5:0]  cnt_a = '0, cnt_b = '0;
  logic        vld_a, err_a, vld_b, err_b;
  logic [31:0] mema, memb;

  // Narrow instance
  logic        restart_s = 1'b0;
  logic        init_busy_s, ovf_s;
  logic        req_a_s = 1'b0;
  logic [4:0]  cnt_a_s = '0;
  logic        req_b_s = 1'b0;
  logic [4:0]  cnt_b_s = '0;
  logic        vld_a_s, err_a_s, vld_b_s, err_b_s;
  logic [15:0] mema_s, memb_s;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_s[$];

  int n_checks = 0;
  int n_pass   = 0;

  longint unsigned fib [DEPTH];

  always #5 clk = ~clk;

  fib_table_gen #(.WIDTH(32), .DEPTH(48), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .init_busy(init_busy), .ovf(ovf),
    .req_a(req_a), .cnt_a(cnt_a), .vld_a(vld_a), .err_a(err_a), .mema(mema),
    .req_b(req_b), .cnt_b(cnt_b), .vld_b(vld_b), .err_b(err_b), .memb(memb)
  );

  fib_table_gen #(.WIDTH(16), .DEPTH(32), .IDX_W(5)) dut16 (
    .clk(clk), .rst(rst), .restart(restart_s),
    .init_busy(init_busy_s), .ovf(ovf_s),
    .req_a(req_a_s), .cnt_a(cnt_a_s), .vld_a(vld_a_s), .err_a(err_a_s), .mema(mema_s),
    .req_b(req_b_s), .cnt_b(cnt_b_s), .vld_b(vld_b_s), .err_b(err_b_s), .memb(memb_s)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic err, input logic [31:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors: compare on every vld, flag any vld with nothing expected.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (vld_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_vld", 1, 0);
        end else begin
          exp_t e;
          e = q_a.pop_front();
          check("a_data", mema, e.data);
          check("a_err", err_a, e.err);
        end
      end
      if (vld_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_vld", 1, 0);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          check("b_data", memb, e.data);
          check("b_err", err_b, e.err);
        end
      end
      if (vld_a_s) begin
        if (q_s.size() == 0) begin
          check("s_unexpected_vld", 1, 0);
        end else begin
          exp_t e;
          e = q_s.pop_front();
          check("s_data", mema_s, e.data);
          check("s_err", err_a_s, e.err);
        end
      end
      if (vld_b_s) begin
        check("s_b_unexpected_vld", 1, 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    fib[0] = 0;
    fib[1] = 1;
    for (int i = 2; i < DEPTH; i++) fib[i] = fib[i-1] + fib[i-2];

    // Reset state
    repeat (3) cyc();
    check("rst_init_busy", init_busy, 1);
    check("rst_ovf", ovf, 0);
    check("rst_vld_a", vld_a, 0);
    check("rst_vld_b", vld_b, 0);
    check("rst_err_a", err_a, 0);
    check("rst_mema", mema, 0);
    check("rst_memb", memb, 0);
    check("rst_s_init_busy", init_busy_s, 1);

    // Release; edge k writes entry k-1. req_a held high the whole time:
    // only requests sampled from edge DEPTH+1 on are served.
    rst = 1'b0;
    for (int k = 1; k <= 2 * DEPTH; k++) begin
      req_a = 1'b1;
      if (k > DEPTH) begin
        cnt_a = 6'(k - DEPTH - 1);
        q_a.push_back(mk(1'b0, 32'(fib[k - DEPTH - 1])));
      end else begin
        cnt_a = 6'((k * 7) % 64);
      end
      cyc();
      if (k == DEPTH - 1 || k == DEPTH) begin
        check($sformatf("fill_busy_edge%0d", k), init_busy, (k < DEPTH) ? 1 : 0);
      end
    end
    req_a = 1'b0;
    cyc();
    check("ovf_default_fill", ovf, 0);

    // Same-cycle reads on both channels, same index, then in/out of range.
    req_a = 1'b1; cnt_a = 6'd10;
    req_b = 1'b1; cnt_b = 6'd10;
    q_a.push_back(mk(1'b0, 32'd55));
    q_b.push_back(mk(1'b0, 32'd55));
    cyc();
    cnt_a = 6'd47; cnt_b = 6'd60;
    q_a.push_back(mk(1'b0, 32'd2971215073));
    q_b.push_back(mk(1'b1, 32'd0));
    cyc();
    req_a = 1'b0; req_b = 1'b0;
    cyc();

    // Narrow instance: overflow at F(25).
    check("s_ovf_after_fill", ovf_s, 1);
    req_a_s = 1'b1; cnt_a_s = 5'd24;
    q_s.push_back(mk(1'b0, 32'd46368));
    cyc();
    cnt_a_s = 5'd25;
`ifdef FIB_SAT_EN
    q_s.push_back(mk(1'b0, 32'd65535));
`else
    q_s.push_back(mk(1'b0, 32'd9489));
`endif
    cyc();
    cnt_a_s = 5'd31;
`ifdef FIB_SAT_EN
    q_s.push_back(mk(1'b0, 32'd65535));
`else
    q_s.push_back(mk(1'b0, 32'd35549));
`endif
    cyc();
    req_a_s = 1'b0;
    cyc();

    // Request one cycle before restart completes; request in restart cycle drops.
    req_a = 1'b1; cnt_a = 6'd20;
    req_b = 1'b1; cnt_b = 6'd60;
    q_a.push_back(mk(1'b0, 32'd6765));
    q_b.push_back(mk(1'b1, 32'd0));
    cyc();
    restart = 1'b1; restart_s = 1'b1;
    req_a = 1'b1; cnt_a = 6'd5;
    req_b = 1'b0;
    cyc();
    restart = 1'b0; restart_s = 1'b0;
    req_a = 1'b0;
    check("restart_busy", init_busy, 1);
    check("restart_ovf", ovf, 0);
    check("restart_s_ovf_cleared", ovf_s, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      cyc();
      if (k == 1 || k == DEPTH - 1 || k == DEPTH) begin
        check($sformatf("refill_busy_edge%0d", k), init_busy, (k < DEPTH) ? 1 : 0);
      end
    end
    check("s_ovf_refill", ovf_s, 1);

    // Reads after refill, back to back.
    req_a = 1'b1; cnt_a = 6'd0;  q_a.push_back(mk(1'b0, 32'd0));
    req_b = 1'b1; cnt_b = 6'd1;  q_b.push_back(mk(1'b0, 32'd1));
    cyc();
    cnt_a = 6'd47; q_a.push_back(mk(1'b0, 32'd2971215073));
    cnt_b = 6'd63; q_b.push_back(mk(1'b1, 32'd0));
    cyc();
    req_a = 1'b0; req_b = 1'b0;
    cyc();

    // Asynchronous reset at fill index 20.
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    repeat (20) cyc();
    rst = 1'b1;
    #1;
    check("midrst_init_busy", init_busy, 1);
    check("midrst_ovf", ovf, 0);
    check("midrst_vld_a", vld_a, 0);
    check("midrst_mema", mema, 0);
    check("midrst_err_b", err_b, 0);
    check("midrst_memb", memb, 0);
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      cyc();
      if (k == DEPTH - 1 || k == DEPTH) begin
        check($sformatf("rst_refill_busy_edge%0d", k), init_busy, (k < DEPTH) ? 1 : 0);
      end
    end
    req_a = 1'b1; cnt_a = 6'd12; q_a.push_back(mk(1'b0, 32'd144));
    req_b = 1'b1; cnt_b = 6'd47; q_b.push_back(mk(1'b0, 32'd2971215073));
    cyc();
    cnt_a = 6'd33; q_a.push_back(mk(1'b0, 32'd3524578));
    cnt_b = 6'd2;  q_b.push_back(mk(1'b0, 32'd1));
    cyc();
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) cyc();

    check("q_a_drained", q_a.size(), 0);
    check("q_b_drained", q_b.size(), 0);
    check("q_s_drained", q_s.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
